// File: rtl/turbo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : turbo_pkg
//  Description : Shared definitions for the turbo decoder iteration control.
//                State encoding (3 bits), SISO half-iteration select values,
//                and block geometry constants shared with the decoder top.
//  Revision    : 1.0 - initial release
// ============================================================================
package turbo_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_LOAD    = 3'd1;
    localparam logic [STATE_W-1:0] ST_D1_GO   = 3'd2;
    localparam logic [STATE_W-1:0] ST_D1_WAIT = 3'd3;
    localparam logic [STATE_W-1:0] ST_D2_GO   = 3'd4;
    localparam logic [STATE_W-1:0] ST_D2_WAIT = 3'd5;
    localparam logic [STATE_W-1:0] ST_OUT     = 3'd6;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = ST_IDLE,
        S_LOAD    = ST_LOAD,
        S_D1_GO   = ST_D1_GO,
        S_D1_WAIT = ST_D1_WAIT,
        S_D2_GO   = ST_D2_GO,
        S_D2_WAIT = ST_D2_WAIT,
        S_OUT     = ST_OUT
    } state_t;

    // SISO half-iteration select: DEC1 = natural order with par1,
    // DEC2 = interleaved order with par2.
    localparam logic SEL_DEC1 = 1'b0;
    localparam logic SEL_DEC2 = 1'b1;

    // Block geometry shared with the decoder top.
    localparam int DEF_N_PLANES = 4;   // soft-bit planes per block
    localparam int PLANE_W      = 2;   // width of the plane index
    localparam int SOFT_W       = 4;   // soft input width in bits
    localparam int BLOCK_LEN    = 21;  // bits per plane word (block size)

    function automatic logic is_go(input state_t s);
        return (s == S_D1_GO) || (s == S_D2_GO);
    endfunction

    function automatic logic is_wait(input state_t s);
        return (s == S_D1_WAIT) || (s == S_D2_WAIT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/turbo_iter_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : turbo_iter_ctrl_if
//  Description : Control bundle between the input framer, the shared
//                SISO/interleaver datapath, the downstream sink and the
//                iteration controller.
//                slave  : controller side (owns all control strobes)
//                master : environment side (framer / datapath / sink)
//  Ports       : start_i, in_valid_i/in_ready_o, load_we_o, plane_idx_o,
//                siso_start_o, siso_sel_o, siso_done_i, ext_bank_o,
//                early_stop_i, iter_cnt_o, out_valid_o/out_ready_i,
//                busy_o, err_o
//  Revision    : 1.0 - initial release
// ============================================================================
interface turbo_iter_ctrl_if #(
    parameter int ITER_W = 4
);
    import turbo_pkg::*;

    logic               start_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic               load_we_o;
    logic [PLANE_W-1:0] plane_idx_o;
    logic               siso_start_o;
    logic               siso_sel_o;
    logic               siso_done_i;
    logic               ext_bank_o;
    logic               early_stop_i;
    logic [ITER_W-1:0]  iter_cnt_o;
    logic               out_valid_o;
    logic               out_ready_i;
    logic               busy_o;
    logic               err_o;

    modport slave (
        input  start_i, in_valid_i, siso_done_i, early_stop_i, out_ready_i,
        output in_ready_o, load_we_o, plane_idx_o, siso_start_o, siso_sel_o,
               ext_bank_o, iter_cnt_o, out_valid_o, busy_o, err_o
    );

    modport master (
        output start_i, in_valid_i, siso_done_i, early_stop_i, out_ready_i,
        input  in_ready_o, load_we_o, plane_idx_o, siso_start_o, siso_sel_o,
               ext_bank_o, iter_cnt_o, out_valid_o, busy_o, err_o
    );

endinterface
`default_nettype wire

// File: rtl/turbo_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : turbo_watchdog
//  Description : SISO completion watchdog. Counts enabled cycles since the
//                last clear; expired is raised combinationally in the enabled
//                cycle that would bring the count to TIMEOUT.
//  Ports       : clk, rst (sync, active-high), clear, enable -> expired
//  Revision    : 1.0 - initial release
// ============================================================================
module turbo_watchdog #(
    parameter int TIMEOUT = 64,
    parameter int TMO_W   = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TMO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TMO_W'(1);
        end
    end

    // Flagged in the TIMEOUT-th enabled cycle itself, so the caller can let a
    // completion arriving in that same cycle take priority.
    assign expired = enable && (count == TMO_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/turbo_iter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : turbo_iter_ctrl
//  Description : Turbo decoder iteration scheduler. Loads N_PLANES soft-bit
//                plane words, alternates DEC1/DEC2 SISO half-iterations with
//                a ping-pong extrinsic bank, stops on MAX_ITER or early stop,
//                then offers the decoded block downstream. A watchdog aborts
//                to IDLE with a sticky error if a SISO never completes.
//  Ports       : clk_p_i, reset_p_i (sync, active-high),
//                bus (turbo_iter_ctrl_if.slave) - all handshakes and strobes
//  Revision    : 1.0 - initial release
// ============================================================================
module turbo_iter_ctrl
    import turbo_pkg::*;
#(
    parameter int MAX_ITER = 8,
    parameter int ITER_W   = 4,
    parameter int N_PLANES = DEF_N_PLANES,
    parameter int TIMEOUT  = 64,
    parameter int TMO_W    = 7
) (
    input  logic             clk_p_i,
    input  logic             reset_p_i,
    turbo_iter_ctrl_if.slave bus
);

    state_t             state;
    state_t             next_state;
    logic [PLANE_W-1:0] plane_idx;
    logic [ITER_W-1:0]  iter_cnt;
    logic [ITER_W-1:0]  iter_next;
    logic               ext_bank;
    logic               siso_sel;
    logic               err;
    logic               accept;
    logic               last_plane;
    logic               iter_limit;
    logic               wd_expired;

    assign accept     = (state == S_LOAD) && bus.in_valid_i;
    assign last_plane = (plane_idx == PLANE_W'(N_PLANES - 1));
    assign iter_next  = iter_cnt + ITER_W'(1);
    assign iter_limit = (iter_next == ITER_W'(MAX_ITER));

    turbo_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TMO_W   (TMO_W)
    ) u_watchdog (
        .clk     (clk_p_i),
        .rst     (reset_p_i),
        .clear   (is_go(state)),
        .enable  (is_wait(state)),
        .expired (wd_expired)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_p_i) begin
        if (reset_p_i) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (bus.start_i) next_state = S_LOAD;
            end
            S_LOAD: begin
                if (accept && last_plane) next_state = S_D1_GO;
            end
            S_D1_GO: next_state = S_D1_WAIT;
            S_D1_WAIT: begin
                // Done is tested before the watchdog so a completion on the
                // timeout cycle is still a normal completion.
                if (bus.siso_done_i)  next_state = S_D2_GO;
                else if (wd_expired)  next_state = S_IDLE;
            end
            S_D2_GO: next_state = S_D2_WAIT;
            S_D2_WAIT: begin
                if (bus.siso_done_i) begin
                    if (bus.early_stop_i || iter_limit) next_state = S_OUT;
                    else                                next_state = S_D1_GO;
                end else if (wd_expired) begin
                    next_state = S_IDLE;
                end
            end
            S_OUT: begin
                if (bus.out_ready_i) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered control outputs and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_p_i) begin
        if (reset_p_i) begin
            plane_idx <= '0;
            iter_cnt  <= '0;
            ext_bank  <= 1'b0;
            siso_sel  <= SEL_DEC1;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        plane_idx <= '0;
                        iter_cnt  <= '0;
                        ext_bank  <= 1'b0;
                        err       <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (accept) plane_idx <= plane_idx + PLANE_W'(1);
                end
                S_D1_WAIT, S_D2_WAIT: begin
                    if (bus.siso_done_i) begin
                        ext_bank <= ~ext_bank;
                        // Bounded by the MAX_ITER exit, so no saturation logic.
                        if (state == S_D2_WAIT) iter_cnt <= iter_next;
                    end else if (wd_expired) begin
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase

            // Select is set on entry to a GO state and held through its WAIT.
            if (next_state == S_D1_GO) begin
                siso_sel <= SEL_DEC1;
            end else if (next_state == S_D2_GO) begin
                siso_sel <= SEL_DEC2;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign bus.in_ready_o   = (state == S_LOAD);
    assign bus.load_we_o    = accept;
    assign bus.plane_idx_o  = plane_idx;
    assign bus.siso_start_o = is_go(state);
    assign bus.siso_sel_o   = siso_sel;
    assign bus.ext_bank_o   = ext_bank;
    assign bus.iter_cnt_o   = iter_cnt;
    assign bus.out_valid_o  = (state == S_OUT);
    assign bus.busy_o       = (state != S_IDLE);
    assign bus.err_o        = err;

endmodule
`default_nettype wire

// File: tb/tb_turbo_iter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_turbo_iter_ctrl
//  Description : Self-checking bench for turbo_iter_ctrl. A per-cycle vector
//                table covers reset, gapped plane loading, the half-iteration
//                sequence and early stop; hand-written sequences cover the
//                full MAX_ITER run, watchdog timeout, done-on-timeout-cycle,
//                output back-pressure and mid-run reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_turbo_iter_ctrl;

    localparam int MAX_ITER = 8;
    localparam int ITER_W   = 4;
    localparam int N_PLANES = 4;
    localparam int TIMEOUT  = 64;
    localparam int TMO_W    = 7;
    localparam int NVEC     = 21;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    turbo_iter_ctrl_if #(.ITER_W(ITER_W)) bus ();

    turbo_iter_ctrl #(
        .MAX_ITER (MAX_ITER),
        .ITER_W   (ITER_W),
        .N_PLANES (N_PLANES),
        .TIMEOUT  (TIMEOUT),
        .TMO_W    (TMO_W)
    ) dut (
        .clk_p_i   (clk),
        .reset_p_i (rst),
        .bus       (bus)
    );

    // stim = {start, in_valid, siso_done, early_stop, out_ready}
    // exp  = {in_ready, load_we, plane_idx[1:0], siso_start, siso_sel,
    //         ext_bank, iter_cnt[3:0], out_valid, busy, err}
    typedef struct packed {
        logic [4:0]  stim;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl [NVEC];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(input logic [4:0] stim, input logic [1:0] rw,
                                input logic [1:0] pidx, input logic [2:0] ssb,
                                input logic [3:0] it, input logic [2:0] obe);
        vec_t v;
        v.stim = stim;
        v.exp  = {rw, pidx, ssb, it, obe};
        return v;
    endfunction

    function automatic logic [13:0] obs();
        return {bus.in_ready_o, bus.load_we_o, bus.plane_idx_o, bus.siso_start_o,
                bus.siso_sel_o, bus.ext_bank_o, bus.iter_cnt_o, bus.out_valid_o,
                bus.busy_o, bus.err_o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply inputs for one cycle at the falling edge; outputs are then
    // stable for inspection until the next rising edge.
    task automatic cyc(input logic [4:0] stim);
        @(negedge clk);
        {bus.start_i, bus.in_valid_i, bus.siso_done_i, bus.early_stop_i, bus.out_ready_i} = stim;
        #1;
    endtask

    initial begin
        int   age;
        int   pulses;
        int   toggles;
        int   sel_bad;
        int   lat;
        int   bad;
        logic prev_bank;

        {bus.start_i, bus.in_valid_i, bus.siso_done_i, bus.early_stop_i, bus.out_ready_i} = 5'b0;

        //            stim      rdy,we pidx  ss,sel,bank iter  ov,busy,err
        tbl[0]  = mk(5'b10000, 2'b00, 2'd0, 3'b000, 4'd0, 3'b000); // reset state, start
        tbl[1]  = mk(5'b01000, 2'b11, 2'd0, 3'b000, 4'd0, 3'b010); // plane 0
        tbl[2]  = mk(5'b00000, 2'b10, 2'd1, 3'b000, 4'd0, 3'b010); // gap
        tbl[3]  = mk(5'b00000, 2'b10, 2'd1, 3'b000, 4'd0, 3'b010); // gap
        tbl[4]  = mk(5'b01000, 2'b11, 2'd1, 3'b000, 4'd0, 3'b010); // plane 1
        tbl[5]  = mk(5'b01000, 2'b11, 2'd2, 3'b000, 4'd0, 3'b010); // plane 2
        tbl[6]  = mk(5'b00000, 2'b10, 2'd3, 3'b000, 4'd0, 3'b010); // gap
        tbl[7]  = mk(5'b01000, 2'b11, 2'd3, 3'b000, 4'd0, 3'b010); // plane 3
        tbl[8]  = mk(5'b01100, 2'b00, 2'd0, 3'b100, 4'd0, 3'b010); // D1_GO, stray valid/done
        tbl[9]  = mk(5'b00110, 2'b00, 2'd0, 3'b000, 4'd0, 3'b010); // D1 done, es ignored
        tbl[10] = mk(5'b00000, 2'b00, 2'd0, 3'b111, 4'd0, 3'b010); // D2_GO
        tbl[11] = mk(5'b00100, 2'b00, 2'd0, 3'b011, 4'd0, 3'b010); // D2 done
        tbl[12] = mk(5'b00000, 2'b00, 2'd0, 3'b100, 4'd1, 3'b010); // D1_GO
        tbl[13] = mk(5'b00000, 2'b00, 2'd0, 3'b000, 4'd1, 3'b010); // D1_WAIT
        tbl[14] = mk(5'b00100, 2'b00, 2'd0, 3'b000, 4'd1, 3'b010); // D1 done
        tbl[15] = mk(5'b00000, 2'b00, 2'd0, 3'b111, 4'd1, 3'b010); // D2_GO
        tbl[16] = mk(5'b00110, 2'b00, 2'd0, 3'b011, 4'd1, 3'b010); // D2 done + early stop
        tbl[17] = mk(5'b10000, 2'b00, 2'd0, 3'b010, 4'd2, 3'b110); // OUT, start ignored
        tbl[18] = mk(5'b00001, 2'b00, 2'd0, 3'b010, 4'd2, 3'b110); // OUT accepted
        tbl[19] = mk(5'b00100, 2'b00, 2'd0, 3'b010, 4'd2, 3'b000); // IDLE, stray done
        tbl[20] = mk(5'b00000, 2'b00, 2'd0, 3'b010, 4'd2, 3'b000); // IDLE

        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            cyc(tbl[i].stim);
            check($sformatf("vec%0d", i), 32'(obs()), 32'(tbl[i].exp));
        end

        // ---- Full MAX_ITER run, SISO done 3 cycles after each start ----
        cyc(5'b10000);
        repeat (N_PLANES) cyc(5'b01000);
        age = 100; pulses = 0; toggles = 0; sel_bad = 0; lat = -1;
        prev_bank = bus.ext_bank_o;
        for (int c = N_PLANES + 1; c < 400 && lat < 0; c++) begin
            cyc({2'b00, (age + 1 == 3), 2'b00});
            age++;
            if (bus.ext_bank_o !== prev_bank) toggles++;
            prev_bank = bus.ext_bank_o;
            if (bus.siso_start_o === 1'b1) begin
                if (bus.siso_sel_o !== pulses[0]) sel_bad++;
                pulses++;
                age = 0;
            end
            if (bus.out_valid_o === 1'b1) lat = c;
        end
        check("full_siso_pulses", 32'(pulses), 32'(16));
        check("full_sel_alternates", 32'(sel_bad), 32'(0));
        check("full_bank_toggles", 32'(toggles), 32'(16));
        check("full_latency", 32'(lat), 32'(N_PLANES + 16 * 4 + 1));
        check("full_iter_cnt", 32'(bus.iter_cnt_o), 32'(MAX_ITER));
        check("full_no_err", 32'(bus.err_o), 32'(0));
        cyc(5'b00001);
        cyc(5'b00000);
        check("full_back_idle", 32'({bus.out_valid_o, bus.busy_o, bus.iter_cnt_o}), 32'({2'b00, 4'd8}));

        // ---- Watchdog timeout in D1_WAIT ----
        cyc(5'b10000);
        repeat (N_PLANES) cyc(5'b01000);
        cyc(5'b00000);
        check("tmo_go", 32'(bus.siso_start_o), 32'(1));
        bad = 0;
        repeat (TIMEOUT) begin
            cyc(5'b00000);
            if (bus.busy_o !== 1'b1 || bus.err_o !== 1'b0 || bus.siso_start_o !== 1'b0) bad++;
        end
        check("tmo_wait_cycles", 32'(bad), 32'(0));
        cyc(5'b00000);
        check("tmo_err", 32'(bus.err_o), 32'(1));
        check("tmo_idle", 32'({bus.busy_o, bus.in_ready_o}), 32'(0));
        cyc(5'b10000);
        check("tmo_err_sticky", 32'(bus.err_o), 32'(1));
        cyc(5'b01000);
        check("tmo_err_cleared", 32'(bus.err_o), 32'(0));
        repeat (N_PLANES - 1) cyc(5'b01000);

        // ---- Done on the timeout cycle wins ----
        cyc(5'b00000);
        repeat (TIMEOUT - 1) cyc(5'b00000);
        cyc(5'b00100);
        cyc(5'b00000);
        check("done_wins", 32'({bus.siso_start_o, bus.siso_sel_o, bus.err_o}), 32'(3'b110));
        cyc(5'b00110);

        // ---- Output back-pressure, start in OUT ignored ----
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            cyc((i == 2) ? 5'b10000 : 5'b00000);
            if (bus.out_valid_o !== 1'b1 || bus.iter_cnt_o !== 4'd1 || bus.busy_o !== 1'b1) bad++;
        end
        check("out_hold", 32'(bad), 32'(0));
        cyc(5'b00001);
        check("out_accept_valid", 32'(bus.out_valid_o), 32'(1));
        cyc(5'b00000);
        check("out_to_idle", 32'({bus.out_valid_o, bus.busy_o, bus.in_ready_o}), 32'(0));

        // ---- Reset in D2_WAIT ----
        cyc(5'b10000);
        repeat (N_PLANES) cyc(5'b01000);
        cyc(5'b00000);
        cyc(5'b00100);
        cyc(5'b00000);
        @(negedge clk);
        {bus.start_i, bus.in_valid_i, bus.siso_done_i, bus.early_stop_i, bus.out_ready_i} = 5'b0;
        rst = 1'b1;
        #1;
        check("pre_rst_d2_wait", 32'({bus.busy_o, bus.ext_bank_o, bus.siso_sel_o}), 32'(3'b111));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_all_zero", 32'(obs()), 32'(0));
        cyc(5'b00100);
        check("idle_stray_done", 32'(obs()), 32'(0));
        cyc(5'b00000);
        check("idle_after_stray", 32'(obs()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
